// File: rtl/char_pkg.sv
// Shared constants, types and helpers for the character line renderer.
package char_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int CODE_W  = 2;
    localparam int ROW_W   = 4;
    localparam int BIT_W   = 3;
    localparam int ADDR_W  = CODE_W + ROW_W;
    localparam int RGB_W   = 3;

    localparam logic [RGB_W-1:0] RGB_BLACK = 3'b000;

    // One slot of the glyph line: valid flag plus glyph code.
    typedef struct packed {
        logic              valid;
        logic [CODE_W-1:0] code;
    } entry_t;

    // Character ROM address: glyph code in the upper bits, glyph row below.
    function automatic logic [ADDR_W-1:0] rom_addr_pack(
        input logic [CODE_W-1:0] code,
        input logic [ROW_W-1:0]  row
    );
        return {code, row};
    endfunction

endpackage

// File: rtl/char_line_renderer_if.sv
// Character ROM interface: the renderer drives address/enable, the ROM returns a row.
interface char_line_renderer_if;
    import char_pkg::*;

    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [GLYPH_W-1:0] rom_data;

    modport master (output rom_en, output rom_addr, input rom_data);
    modport slave  (input rom_en, input rom_addr, output rom_data);

endinterface

// File: rtl/char_line_buf.sv
// Glyph line buffer with cursor: one command-driven write port and an
// asynchronous read port used by the render pipeline.
module char_line_buf
    import char_pkg::*;
#(
    parameter int   NCHARS = 16,
    localparam int  IDX_W  = $clog2(NCHARS),
    localparam int  CUR_W  = IDX_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CODE_W-1:0] wr_char,
    input  logic              bksp,
    input  logic              clr,
    input  logic [IDX_W-1:0]  rd_idx,
    output entry_t            rd_entry,
    output logic [CUR_W-1:0]  cursor,
    output logic              full
);

    localparam logic [CUR_W-1:0] NCHARS_C = CUR_W'(NCHARS);

    entry_t           entries_r [NCHARS];
    logic [CUR_W-1:0] cursor_r;
    logic             full_r;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] bk_idx_s;
    logic [CUR_W-1:0] cursor_inc_s;

    // Slot addressed by the cursor and the slot just before it.
    always_comb begin
        wr_idx_s     = cursor_r[IDX_W-1:0];
        bk_idx_s     = wr_idx_s - IDX_W'(1'b1);
        cursor_inc_s = cursor_r + CUR_W'(1'b1);
    end

    // Line edits with clear over backspace over append; a full line drops writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCHARS; i++) begin
                entries_r[i] <= '0;
            end
            cursor_r <= '0;
            full_r   <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < NCHARS; i++) begin
                entries_r[i].valid <= 1'b0;
            end
            cursor_r <= '0;
            full_r   <= 1'b0;
        end else if (bksp) begin
            if (cursor_r != '0) begin
                entries_r[bk_idx_s].valid <= 1'b0;
                cursor_r <= cursor_r - CUR_W'(1'b1);
                full_r   <= 1'b0;
            end else begin
                cursor_r <= cursor_r;
                full_r   <= full_r;
            end
        end else if (wr_en) begin
            if (!full_r) begin
                entries_r[wr_idx_s].valid <= 1'b1;
                entries_r[wr_idx_s].code  <= wr_char;
                cursor_r <= cursor_inc_s;
                full_r   <= (cursor_inc_s == NCHARS_C);
            end else begin
                cursor_r <= cursor_r;
                full_r   <= full_r;
            end
        end else begin
            cursor_r <= cursor_r;
            full_r   <= full_r;
        end
    end

    assign rd_entry = entries_r[rd_idx];
    assign cursor   = cursor_r;
    assign full     = full_r;

endmodule

// File: rtl/char_line_renderer.sv
// Text-line pixel renderer: two pix_en-gated stages turn the current
// coordinate into a glyph ROM lookup and then a serial colour pixel, with
// the syncs carried through the same stages so they stay aligned with rgb.
module char_line_renderer
    import char_pkg::*;
#(
    parameter int               NCHARS = 16,
    parameter int               X0     = 256,
    parameter int               Y0     = 232,
    parameter logic [RGB_W-1:0] FG_RGB = 3'b111,
    parameter logic [RGB_W-1:0] BG_RGB = 3'b001,
    localparam int              IDX_W  = $clog2(NCHARS),
    localparam int              CUR_W  = IDX_W + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pix_en,
    input  logic [9:0]              pixel_x,
    input  logic [9:0]              pixel_y,
    input  logic                    video_on,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    wr_en,
    input  logic [CODE_W-1:0]       wr_char,
    input  logic                    bksp,
    input  logic                    clr,
    char_line_renderer_if.master    rom,
    output logic [RGB_W-1:0]        rgb,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic [CUR_W-1:0]        cursor,
    output logic                    full
);

    // Signed 11-bit box geometry so coordinates left of / above the box go negative.
    localparam logic signed [10:0] X0_S    = 11'(X0);
    localparam logic signed [10:0] Y0_S    = 11'(Y0);
    localparam logic signed [10:0] BOX_W_S = 11'(GLYPH_W * NCHARS);
    localparam logic signed [10:0] BOX_H_S = 11'(GLYPH_H);

    logic signed [10:0] dx_s;
    logic signed [10:0] dy_s;
    logic               in_box_s;
    logic [IDX_W-1:0]   rd_idx_s;
    entry_t             rd_entry_s;

    // Stage A registers
    logic               in_box_a_r;
    logic               vis_a_r;
    logic               lit_a_r;
    logic [CODE_W-1:0]  code_a_r;
    logic [ROW_W-1:0]   row_a_r;
    logic [BIT_W-1:0]   bit_a_r;
    logic               hs_a_r;
    logic               vs_a_r;

    // Stage B registers and their next-value logic
    logic [RGB_W-1:0]   rgb_r;
    logic               hs_b_r;
    logic               vs_b_r;
    logic [BIT_W-1:0]   px_sel_s;
    logic               px_s;
    logic [RGB_W-1:0]   rgb_next_s;

    char_line_buf #(.NCHARS(NCHARS)) u_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_char  (wr_char),
        .bksp     (bksp),
        .clr      (clr),
        .rd_idx   (rd_idx_s),
        .rd_entry (rd_entry_s),
        .cursor   (cursor),
        .full     (full)
    );

    // Box-relative coordinate, box membership and the glyph slot under the pixel.
    always_comb begin
        dx_s     = $signed({1'b0, pixel_x}) - X0_S;
        dy_s     = $signed({1'b0, pixel_y}) - Y0_S;
        in_box_s = video_on
                   && (dx_s >= 11'sd0) && (dx_s < BOX_W_S)
                   && (dy_s >= 11'sd0) && (dy_s < BOX_H_S);
        rd_idx_s = dx_s[IDX_W+2:3];
    end

    // Stage A: capture glyph, row, bit position and visibility for the current pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_box_a_r <= 1'b0;
            vis_a_r    <= 1'b0;
            lit_a_r    <= 1'b0;
            code_a_r   <= '0;
            row_a_r    <= '0;
            bit_a_r    <= '0;
            hs_a_r     <= 1'b1;
            vs_a_r     <= 1'b1;
        end else if (pix_en) begin
            in_box_a_r <= in_box_s;
            vis_a_r    <= video_on;
            lit_a_r    <= in_box_s && rd_entry_s.valid;
            code_a_r   <= rd_entry_s.code;
            row_a_r    <= dy_s[ROW_W-1:0];
            bit_a_r    <= dx_s[BIT_W-1:0];
            hs_a_r     <= hsync_in;
            vs_a_r     <= vsync_in;
        end else begin
            in_box_a_r <= in_box_a_r;
            vis_a_r    <= vis_a_r;
            lit_a_r    <= lit_a_r;
            code_a_r   <= code_a_r;
            row_a_r    <= row_a_r;
            bit_a_r    <= bit_a_r;
            hs_a_r     <= hs_a_r;
            vs_a_r     <= vs_a_r;
        end
    end

    assign rom.rom_en   = lit_a_r;
    assign rom.rom_addr = rom_addr_pack(code_a_r, row_a_r);

    // Pick the glyph bit (MSB is leftmost) and map it to a colour.
    always_comb begin
        px_sel_s   = BIT_W'(GLYPH_W - 1) - bit_a_r;
        px_s       = rom.rom_data[px_sel_s] && lit_a_r;
        rgb_next_s = RGB_BLACK;
        if (!vis_a_r) begin
            rgb_next_s = RGB_BLACK;
        end else if (px_s) begin
            rgb_next_s = FG_RGB;
        end else if (in_box_a_r) begin
            rgb_next_s = BG_RGB;
        end else begin
            rgb_next_s = RGB_BLACK;
        end
    end

    // Stage B: register the output colour and the aligned syncs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_r  <= RGB_BLACK;
            hs_b_r <= 1'b1;
            vs_b_r <= 1'b1;
        end else if (pix_en) begin
            rgb_r  <= rgb_next_s;
            hs_b_r <= hs_a_r;
            vs_b_r <= vs_a_r;
        end else begin
            rgb_r  <= rgb_r;
            hs_b_r <= hs_b_r;
            vs_b_r <= vs_b_r;
        end
    end

    assign rgb       = rgb_r;
    assign hsync_out = hs_b_r;
    assign vsync_out = vs_b_r;

endmodule

// File: tb/tb_char_line_renderer.sv
// Self-checking bench for char_line_renderer: command table for the line
// buffer, scoreboarded pixel scans, and hand sequences for corner cases.
module tb_char_line_renderer;
    import char_pkg::*;

    localparam int         NCHARS = 16;
    localparam int         X0     = 256;
    localparam int         Y0     = 232;
    localparam logic [2:0] FG     = 3'b111;
    localparam logic [2:0] BG     = 3'b001;

    logic       clk;
    logic       reset;
    logic       pix_en;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync_in;
    logic       vsync_in;
    logic       wr_en;
    logic [1:0] wr_char;
    logic       bksp;
    logic       clr;
    logic [2:0] rgb;
    logic       hsync_out;
    logic       vsync_out;
    logic [4:0] cursor;
    logic       full;

    char_line_renderer_if rom_if ();

    // Bench ROM: distinct rows per glyph/row; address 6'b010000 gives 8'b00111100.
    function automatic logic [7:0] rom_fn(input logic [5:0] a);
        return 8'b00111100 ^ {a[3:0], 4'b0000} ^ {6'b000000, a[5:4] ^ 2'b01};
    endfunction

    assign rom_if.rom_data = rom_fn(rom_if.rom_addr);

    char_line_renderer dut (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .video_on  (video_on),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .wr_en     (wr_en),
        .wr_char   (wr_char),
        .bksp      (bksp),
        .clr       (clr),
        .rom       (rom_if.master),
        .rgb       (rgb),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .cursor    (cursor),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    bit         mvalid [NCHARS];
    logic [1:0] mcode  [NCHARS];
    int         mcur;

    task automatic model_clear();
        for (int i = 0; i < NCHARS; i++) begin
            mvalid[i] = 1'b0;
            mcode[i]  = 2'b00;
        end
        mcur = 0;
    endtask

    task automatic model_cmd(input bit w, input logic [1:0] ch, input bit b, input bit c);
        if (c) begin
            for (int i = 0; i < NCHARS; i++) mvalid[i] = 1'b0;
            mcur = 0;
        end else if (b) begin
            if (mcur > 0) begin
                mcur--;
                mvalid[mcur] = 1'b0;
            end
        end else if (w) begin
            if (mcur < NCHARS) begin
                mvalid[mcur] = 1'b1;
                mcode[mcur]  = ch;
                mcur++;
            end
        end
    endtask

    typedef struct {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       lit;
        logic [5:0] addr;
    } exp_t;

    function automatic exp_t model_px(input int x, input int y, input bit von,
                                      input bit hs, input bit vs);
        exp_t       e;
        int         dx;
        int         dy;
        int         idx;
        bit         inbox;
        logic [7:0] row;
        logic [3:0] r;
        logic [2:0] b;
        dx     = x - X0;
        dy     = y - Y0;
        e.hs   = hs;
        e.vs   = vs;
        e.lit  = 1'b0;
        e.addr = 6'd0;
        e.rgb  = 3'b000;
        inbox  = von && (dx >= 0) && (dx < 8 * NCHARS) && (dy >= 0) && (dy < 16);
        if (inbox) begin
            idx    = dx / 8;
            r      = dy[3:0];
            b      = dx[2:0];
            e.lit  = mvalid[idx];
            e.addr = {mcode[idx], r};
            row    = rom_fn(e.addr);
            e.rgb  = (e.lit && row[7 - b]) ? FG : BG;
        end
        return e;
    endfunction

    function automatic bit hs_of(input int x);
        return !((x >= 656) && (x < 752));
    endfunction

    function automatic bit vs_of(input int y);
        return !((y >= 490) && (y < 492));
    endfunction

    // ---------------- scoreboarded pixel scan ----------------
    exp_t q[$];
    exp_t last_e;
    bit   have_last;

    task automatic step(input int x, input int y);
        exp_t e;
        exp_t o;
        bit   von;
        von      = (x < 640) && (y < 480);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        hsync_in = hs_of(x);
        vsync_in = vs_of(y);
        pix_en   = 1'b1;
        e = model_px(x, y, von, hs_of(x), vs_of(y));
        q.push_back(e);
        tick();
        check("rom_en", 32'(rom_if.rom_en), 32'(e.lit));
        if (e.lit) check("rom_addr", 32'(rom_if.rom_addr), 32'(e.addr));
        if (q.size() >= 2) begin
            o = q.pop_front();
            check("pix_out", 32'({rgb, hsync_out, vsync_out}), 32'({o.rgb, o.hs, o.vs}));
            last_e    = o;
            have_last = 1'b1;
        end
    endtask

    task automatic freeze5();
        pix_en   = 1'b0;
        pixel_x  = 10'($urandom);
        pixel_y  = 10'($urandom);
        hsync_in = ~hsync_in;
        vsync_in = ~vsync_in;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("freeze", 32'({rgb, hsync_out, vsync_out}),
                  32'({last_e.rgb, last_e.hs, last_e.vs}));
        end
    endtask

    task automatic scan_row(input int y, input int xa, input int xb, input int xs, input int xf);
        for (int x = xa; x <= xb; x += xs) begin
            step(x, y);
            if (x == xf && have_last) freeze5();
        end
    endtask

    task automatic scan_box(input int freeze_row);
        q.delete();
        have_last = 1'b0;
        for (int y = Y0 - 1; y <= Y0 + 16; y++) begin
            scan_row(y, X0 - 4, X0 + 131, 1, (y == freeze_row) ? X0 + 40 : -1);
        end
        pix_en = 1'b0;
    endtask

    task automatic scan_sparse();
        int rows[5];
        rows = '{0, 231, 480, 490, 524};
        q.delete();
        have_last = 1'b0;
        for (int i = 0; i < 5; i++) scan_row(rows[i], 0, 799, 3, -1);
        pix_en = 1'b0;
    endtask

    // ---------------- buffer command table ----------------
    typedef struct {
        bit         wr;
        logic [1:0] ch;
        bit         bk;
        bit         cl;
        int         exp_cur;
        bit         exp_full;
    } cmd_t;

    cmd_t tbl[23];

    task automatic apply_cmd(input int i);
        wr_en   = tbl[i].wr;
        wr_char = tbl[i].ch;
        bksp    = tbl[i].bk;
        clr     = tbl[i].cl;
        tick();
        wr_en = 1'b0;
        bksp  = 1'b0;
        clr   = 1'b0;
        model_cmd(tbl[i].wr, tbl[i].ch, tbl[i].bk, tbl[i].cl);
        check($sformatf("cursor[%0d]", i), 32'(cursor), 32'(tbl[i].exp_cur));
        check($sformatf("full[%0d]", i), 32'(full), 32'(tbl[i].exp_full));
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0; pixel_x = '0; pixel_y = '0;
        video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        wr_en = 1'b0; wr_char = 2'b00; bksp = 1'b0; clr = 1'b0;
        have_last = 1'b0;
        model_clear();

        // 0: backspace at cursor 0; 1..17: writes (17th dropped); 18..22: edits
        tbl[0] = '{wr:0, ch:2'd0, bk:1, cl:0, exp_cur:0, exp_full:0};
        for (int i = 1; i <= 17; i++) begin
            tbl[i] = '{wr:1, ch:2'((i - 1) % 4), bk:0, cl:0,
                       exp_cur:(i < 16) ? i : 16, exp_full:(i >= 16)};
        end
        tbl[17].ch = 2'd0;
        tbl[18] = '{wr:0, ch:2'd0, bk:1, cl:0, exp_cur:15, exp_full:0};
        tbl[19] = '{wr:1, ch:2'd2, bk:0, cl:0, exp_cur:16, exp_full:1};
        tbl[20] = '{wr:1, ch:2'd3, bk:0, cl:1, exp_cur:0,  exp_full:0};
        tbl[21] = '{wr:0, ch:2'd0, bk:1, cl:0, exp_cur:0,  exp_full:0};
        tbl[22] = '{wr:1, ch:2'd1, bk:0, cl:0, exp_cur:1,  exp_full:0};

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("rst_rgb", 32'(rgb), 32'(3'b000));
        check("rst_hs", 32'(hsync_out), 32'(1'b1));
        check("rst_vs", 32'(vsync_out), 32'(1'b1));
        check("rst_rom_en", 32'(rom_if.rom_en), 32'(1'b0));
        check("rst_rom_addr", 32'(rom_if.rom_addr), 32'(6'd0));
        check("rst_cursor", 32'(cursor), 32'(5'd0));
        check("rst_full", 32'(full), 32'(1'b0));

        // Empty line: black outside, background inside, ROM idle
        scan_sparse();
        scan_box(-1);

        // Fill past capacity, then render with a mid-line stall
        for (int i = 0; i <= 17; i++) apply_cmd(i);
        scan_box(Y0 + 5);
        q.delete(); have_last = 1'b0;
        scan_row(10, 640, 780, 1, 700);
        scan_row(491, 640, 780, 1, 700);
        pix_en = 1'b0;

        // Backspace/refill, clear beats write, backspace at 0, single write
        for (int i = 18; i <= 22; i++) apply_cmd(i);

        // Glyph 1 at slot 0: address and lit/unlit bits, box edges
        pixel_y = 10'(Y0); video_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        pix_en  = 1'b1;
        pixel_x = 10'(X0 + 2);
        tick();
        check("addr_x2", 32'(rom_if.rom_addr), 32'(6'b010000));
        check("en_x2", 32'(rom_if.rom_en), 32'(1'b1));
        pixel_x = 10'(X0);
        tick();
        check("rgb_x2", 32'(rgb), 32'(FG));
        pixel_x = 10'(X0 - 1);
        tick();
        check("rgb_x0", 32'(rgb), 32'(BG));
        check("en_left", 32'(rom_if.rom_en), 32'(1'b0));
        pixel_x = 10'(X0); pixel_y = 10'(Y0 + 16);
        tick();
        check("rgb_left", 32'(rgb), 32'(3'b000));
        check("en_below", 32'(rom_if.rom_en), 32'(1'b0));
        pixel_x = 10'(X0 + 2); pixel_y = 10'(Y0);
        tick();
        check("rgb_below", 32'(rgb), 32'(3'b000));
        pix_en = 1'b0;

        // Remaining slots invalid after clear
        q.delete(); have_last = 1'b0;
        scan_row(Y0, X0 - 4, X0 + 131, 1, -1);
        pix_en = 1'b0;

        // Reset mid-line blanks rgb on the next clk
        pixel_x = 10'(X0 + 2); pixel_y = 10'(Y0); video_on = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0; pix_en = 1'b1;
        tick(); tick();
        check("pre_rst_rgb", 32'({rgb, hsync_out, vsync_out}), 32'({FG, 1'b0, 1'b0}));
        pix_en = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        check("mid_rst_out", 32'({rgb, hsync_out, vsync_out}), 32'({3'b000, 1'b1, 1'b1}));
        check("mid_rst_cursor", 32'(cursor), 32'(5'd0));

        // Pipeline restarts with an empty line
        q.delete(); have_last = 1'b0;
        scan_row(Y0 + 1, X0 - 4, X0 + 131, 1, -1);
        pix_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
